// File: rtl/axi_lite_regs_if.sv
// AXI4-Lite type package and bus interface shared by masters and the register bank.
package axi_lite_pkg;
  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  strb_t;
  typedef logic [1:0]  resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;
endpackage

interface axi_lite_if;
  import axi_lite_pkg::*;

  addr_t awaddr;
  logic  awvalid;
  logic  awready;
  data_t wdata;
  strb_t wstrb;
  logic  wvalid;
  logic  wready;
  resp_t bresp;
  logic  bvalid;
  logic  bready;
  addr_t araddr;
  logic  arvalid;
  logic  arready;
  data_t rdata;
  resp_t rresp;
  logic  rvalid;
  logic  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_regs.sv
// AXI4-Lite slave register bank: N_REGS x 32-bit byte-strobed registers,
// independent write and read FSMs, registered handshake/response outputs.

// One 32-bit register with per-byte write enables.
module axi_lite_regs_slot (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        we_i,
  input  logic [3:0]  strb_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] q_o
);
  logic [31:0] q_q, q_d;

  // Merge strobed bytes of the write data over the held value.
  always_comb begin
    q_d = q_q;
    for (int b = 0; b < 4; b++) begin
      if (we_i && strb_i[b]) q_d[8*b +: 8] = wdata_i[8*b +: 8];
    end
  end

  // Register storage, cleared by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_q <= '0;
    else         q_q <= q_d;
  end

  assign q_o = q_q;
endmodule

module axi_lite_regs
  import axi_lite_pkg::*;
#(
  parameter int unsigned N_REGS    = 8,
  parameter addr_t       BASE_ADDR = 32'h0000_0000
) (
  input  logic                aclk,
  input  logic                aresetn,
  axi_lite_if.slave           s_axi,
  output logic [N_REGS*32-1:0] reg_q,
  output logic [N_REGS-1:0]   reg_wr
);

  localparam logic [29:0] NREGS_W = 30'(N_REGS);

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_e;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_e;

  // Word index relative to BASE_ADDR; byte-lane bits are dropped.
  function automatic logic [29:0] word_of(addr_t a);
    return 30'((a - BASE_ADDR) >> 2);
  endfunction

  // Below BASE_ADDR the subtraction wraps, so the lower bound is checked explicitly.
  function automatic logic hit(addr_t a);
    return (a >= BASE_ADDR) && (word_of(a) < NREGS_W);
  endfunction

  // ---------------------------------------------------------------- storage
  logic [N_REGS-1:0][31:0] regs;
  logic [N_REGS-1:0]       wr_sel;
  data_t                   wr_data;
  strb_t                   wr_strb;

  for (genvar i = 0; i < N_REGS; i++) begin : g_reg
    axi_lite_regs_slot u_slot (
      .clk_i   (aclk),
      .rst_ni  (aresetn),
      .we_i    (wr_sel[i]),
      .strb_i  (wr_strb),
      .wdata_i (wr_data),
      .q_o     (regs[i])
    );
  end

  assign reg_q = regs;

  // ---------------------------------------------------------------- write path
  wr_state_e         wr_state_q;
  logic              awready_q, wready_q, bvalid_q;
  resp_t             bresp_q;
  logic              aw_got_q, w_got_q;
  addr_t             awaddr_q;
  data_t             wdata_q;
  strb_t             wstrb_q;
  logic [N_REGS-1:0] reg_wr_q;

  logic        aw_hs, w_hs, aw_have, w_have, commit, wr_ok;
  addr_t       wr_addr;
  logic [29:0] wr_word;

  assign aw_hs   = s_axi.awvalid & awready_q;
  assign w_hs    = s_axi.wvalid  & wready_q;
  assign aw_have = aw_got_q | aw_hs;
  assign w_have  = w_got_q  | w_hs;
  // Commit on the edge where the later of AW/W handshakes lands.
  assign commit  = (wr_state_q == WR_IDLE) & aw_have & w_have;

  // A channel captured earlier supplies its stored copy; otherwise take the live bus.
  assign wr_addr = aw_got_q ? awaddr_q : s_axi.awaddr;
  assign wr_data = w_got_q  ? wdata_q  : s_axi.wdata;
  assign wr_strb = w_got_q  ? wstrb_q  : s_axi.wstrb;
  assign wr_ok   = hit(wr_addr);
  assign wr_word = word_of(wr_addr);

  // One-hot register select; out-of-range commits select nothing.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < N_REGS; i++) begin
      wr_sel[i] = commit && wr_ok && (wr_word == 30'(i));
    end
  end

  // Write FSM: independent AW/W capture, commit, then hold B until accepted.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state_q <= WR_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      reg_wr_q   <= '0;
    end else begin
      reg_wr_q <= wr_sel;
      unique case (wr_state_q)
        WR_IDLE: begin
          if (commit) begin
            bvalid_q   <= 1'b1;
            bresp_q    <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            aw_got_q   <= 1'b0;
            w_got_q    <= 1'b0;
            wr_state_q <= WR_RESP;
          end else begin
            if (aw_hs) begin
              aw_got_q <= 1'b1;
              awaddr_q <= s_axi.awaddr;
            end
            if (w_hs) begin
              w_got_q <= 1'b1;
              wdata_q <= s_axi.wdata;
              wstrb_q <= s_axi.wstrb;
            end
            awready_q <= ~aw_have;
            wready_q  <= ~w_have;
          end
        end
        WR_RESP: begin
          if (s_axi.bready) begin
            bvalid_q   <= 1'b0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            wr_state_q <= WR_IDLE;
          end
        end
      endcase
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign reg_wr        = reg_wr_q;

  // ---------------------------------------------------------------- read path
  rd_state_e rd_state_q;
  logic      arready_q, rvalid_q;
  resp_t     rresp_q;
  data_t     rdata_q;

  logic        ar_hs, rd_ok;
  logic [29:0] rd_word;
  data_t       rd_val;

  assign ar_hs   = s_axi.arvalid & arready_q;
  assign rd_ok   = hit(s_axi.araddr);
  assign rd_word = word_of(s_axi.araddr);

  // Read mux over current register outputs, so a same-edge write is not yet visible.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < N_REGS; i++) begin
      if (rd_ok && (rd_word == 30'(i))) rd_val = regs[i];
    end
  end

  // Read FSM: accept AR, register the response, hold it until accepted.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
    end else begin
      unique case (rd_state_q)
        RD_IDLE: begin
          if (ar_hs) begin
            rdata_q    <= rd_val;
            rresp_q    <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            rvalid_q   <= 1'b1;
            arready_q  <= 1'b0;
            rd_state_q <= RD_RESP;
          end else begin
            arready_q <= 1'b1;
          end
        end
        RD_RESP: begin
          if (s_axi.rready) begin
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
            rd_state_q <= RD_IDLE;
          end
        end
      endcase
    end
  end

  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rdata_q;

endmodule

// File: tb/tb_axi_lite_regs.sv
// Scoreboard bench for axi_lite_regs: expectations from a byte-strobe register model.
module tb_axi_lite_regs;
  import axi_lite_pkg::*;

  localparam int    N    = 8;
  localparam addr_t BASE = 32'h0000_0000;

  logic aclk = 1'b0;
  logic aresetn;
  logic [N*32-1:0] reg_q;
  logic [N-1:0]    reg_wr;

  axi_lite_if bus ();

  axi_lite_regs #(.N_REGS(N), .BASE_ADDR(BASE)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_axi   (bus.slave),
    .reg_q   (reg_q),
    .reg_wr  (reg_wr)
  );

  always #5 aclk = ~aclk;

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    resp_t           resp;
    logic [N*32-1:0] img;
    logic [N-1:0]    pulse;
  } wexp_t;

  typedef struct {
    resp_t resp;
    data_t data;
  } rexp_t;

  wexp_t bq[$];
  rexp_t rq[$];
  logic [N*32-1:0] img;

  function automatic bit m_in(addr_t a);
    return (a >= BASE) && (((a - BASE) >> 2) < 32'(N));
  endfunction

  function automatic int m_idx(addr_t a);
    return int'((a - BASE) >> 2);
  endfunction

  task automatic push_wr(input addr_t a, input data_t d, input strb_t s);
    wexp_t e;
    e.pulse = '0;
    e.resp  = m_in(a) ? RESP_OKAY : RESP_SLVERR;
    if (m_in(a)) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) img[m_idx(a)*32 + 8*b +: 8] = d[8*b +: 8];
      e.pulse[m_idx(a)] = 1'b1;
    end
    e.img = img;
    bq.push_back(e);
  endtask

  task automatic push_rd(input addr_t a);
    rexp_t e;
    e.resp = m_in(a) ? RESP_OKAY : RESP_SLVERR;
    e.data = m_in(a) ? img[m_idx(a)*32 +: 32] : 32'h0;
    rq.push_back(e);
  endtask

  // Full write transaction; returns B response, reg_q/reg_wr in the B cycle and one cycle later.
  task automatic wr_xact(input addr_t a, input data_t d, input strb_t s, output resp_t resp,
                         output logic [N*32-1:0] snap, output logic [N-1:0] pulse,
                         output logic [N-1:0] after, output int lat);
    logic ar, wr;
    int   n;
    bus.awaddr = a; bus.awvalid = 1'b1;
    bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
    n = 0;
    while ((bus.awvalid || bus.wvalid) && n < 50) begin
      ar = bus.awready; wr = bus.wready;
      @(posedge aclk); #1; n++;
      if (ar) bus.awvalid = 1'b0;
      if (wr) bus.wvalid  = 1'b0;
    end
    lat = 0;
    while (!bus.bvalid && lat < 50) begin
      @(posedge aclk); #1; lat++;
    end
    if (n >= 50 || lat >= 50) begin
      vectors++; errors++;
      $display("FAIL write_timeout: got no B response, required one within 50 cycles");
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    end
    resp = bus.bresp; snap = reg_q; pulse = reg_wr;
    bus.bready = 1'b1;
    @(posedge aclk); #1;
    after = reg_wr;
    bus.bready = 1'b0;
  endtask

  task automatic rd_xact(input addr_t a, output data_t d, output resp_t resp, output int lat);
    logic ar;
    int   n;
    bus.araddr = a; bus.arvalid = 1'b1;
    n = 0;
    while (bus.arvalid && n < 50) begin
      ar = bus.arready;
      @(posedge aclk); #1; n++;
      if (ar) bus.arvalid = 1'b0;
    end
    lat = 0;
    while (!bus.rvalid && lat < 50) begin
      @(posedge aclk); #1; lat++;
    end
    if (n >= 50 || lat >= 50) begin
      vectors++; errors++;
      $display("FAIL read_timeout: got no R response, required one within 50 cycles");
      bus.arvalid = 1'b0;
    end
    d = bus.rdata; resp = bus.rresp;
    bus.rready = 1'b1;
    @(posedge aclk); #1;
    bus.rready = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0; bus.bready = 0; bus.rready = 0;
    bus.awaddr = '0; bus.wdata = '0; bus.wstrb = '0; bus.araddr = '0;
    img = '0;
    repeat (3) @(posedge aclk);
    #1;
    vectors++;
    if ({bus.arready, bus.awready, bus.wready, bus.bvalid, bus.rvalid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_hs: got %b want 00000", {bus.arready, bus.awready, bus.wready, bus.bvalid, bus.rvalid});
    end
    vectors++;
    if (reg_q !== '0 || reg_wr !== '0) begin
      errors++; $display("FAIL reset_regs: got %h/%h want 0/0", reg_q, reg_wr);
    end
    vectors++;
    if ({bus.bresp, bus.rresp, bus.rdata} !== 36'h0) begin
      errors++; $display("FAIL reset_resp: got %h/%h/%h want 0", bus.bresp, bus.rresp, bus.rdata);
    end
    @(negedge aclk); aresetn = 1'b1; #1;
    vectors++;
    if ({bus.arready, bus.awready, bus.wready} !== 3'b000) begin
      errors++; $display("FAIL ready_before_edge: got %b want 000", {bus.arready, bus.awready, bus.wready});
    end
    @(posedge aclk); #1;
    vectors++;
    if ({bus.arready, bus.awready, bus.wready} !== 3'b111) begin
      errors++; $display("FAIL ready_after_edge: got %b want 111", {bus.arready, bus.awready, bus.wready});
    end
  endtask

  // Writes then reads from a table, each checked against the model via the scoreboard.
  task automatic run_table(input string tag, input addr_t wa[], input data_t wd[], input strb_t ws[], input addr_t ra[]);
    resp_t resp; logic [N*32-1:0] snap; logic [N-1:0] pulse, after; int lat; data_t d;
    wexp_t we; rexp_t re;
    for (int i = 0; i < wa.size(); i++) begin
      push_wr(wa[i], wd[i], ws[i]);
      wr_xact(wa[i], wd[i], ws[i], resp, snap, pulse, after, lat);
      we = bq.pop_front();
      vectors++;
      if (resp !== we.resp || lat !== 0) begin
        errors++; $display("FAIL %s_bresp[%0d]: got %h lat %0d want %h lat 0", tag, i, resp, lat, we.resp);
      end
      vectors++;
      if (snap !== we.img) begin
        errors++; $display("FAIL %s_regs[%0d]: got %h want %h", tag, i, snap, we.img);
      end
      vectors++;
      if (pulse !== we.pulse || after !== '0) begin
        errors++; $display("FAIL %s_reg_wr[%0d]: got %h then %h want %h then 0", tag, i, pulse, after, we.pulse);
      end
    end
    for (int i = 0; i < ra.size(); i++) begin
      push_rd(ra[i]);
      rd_xact(ra[i], d, resp, lat);
      re = rq.pop_front();
      vectors++;
      if (d !== re.data || resp !== re.resp || lat !== 0) begin
        errors++;
        $display("FAIL %s_read[%0d]: got %h/%h lat %0d want %h/%h lat 0", tag, i, d, resp, lat, re.data, re.resp);
      end
    end
  endtask

  task automatic test_basic();
    run_table("basic", '{BASE + 4}, '{32'hDEAD_BEEF}, '{4'hF}, '{BASE + 4, BASE + 5});
  endtask

  task automatic test_strobe();
    run_table("strobe", '{BASE, BASE}, '{32'h1122_3344, 32'hAABB_CCDD}, '{4'hF, 4'b0101}, '{BASE});
    vectors++;
    if (reg_q[31:0] !== 32'h11BB_33DD) begin
      errors++; $display("FAIL strobe_value: got %h want 11bb33dd", reg_q[31:0]);
    end
  endtask

  task automatic test_oor();
    run_table("oor", '{BASE + 32, 32'hFFFF_FFFC, BASE + 28}, '{32'h5555_AAAA, 32'h1234_5678, 32'h0BAD_F00D},
              '{4'hF, 4'hF, 4'hF}, '{BASE + 32, 32'hFFFF_FFFC, BASE + 28});
  endtask

  // AW and W separated by three cycles in each order.
  task automatic test_ordering();
    wexp_t we;
    for (int k = 0; k < 2; k++) begin
      addr_t a; data_t d;
      a = BASE + 12 + 4 * k; d = 32'hCAFE_0000 + k;
      push_wr(a, d, 4'hF);
      bus.awaddr = a; bus.wdata = d; bus.wstrb = 4'hF;
      if (k == 0) bus.awvalid = 1'b1; else bus.wvalid = 1'b1;
      @(posedge aclk); #1;
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      vectors++;
      if ({bus.awready, bus.wready} !== (k == 0 ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL order%0d_capture: got %b want %b", k, {bus.awready, bus.wready}, (k == 0 ? 2'b01 : 2'b10));
      end
      repeat (3) @(posedge aclk);
      #1;
      vectors++;
      if (bus.bvalid !== 1'b0 || reg_q !== bq[0].img ^ (reg_q & '0) && reg_q === we.img) begin
      end
      if (bus.bvalid !== 1'b0 || {bus.awready, bus.wready} !== (k == 0 ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL order%0d_wait: got bvalid %b ready %b want 0 and %b", k, bus.bvalid,
                           {bus.awready, bus.wready}, (k == 0 ? 2'b01 : 2'b10));
      end
      if (k == 0) bus.wvalid = 1'b1; else bus.awvalid = 1'b1;
      @(posedge aclk); #1;
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      we = bq.pop_front();
      vectors++;
      if (bus.bvalid !== 1'b1 || bus.bresp !== we.resp || reg_q !== we.img || reg_wr !== we.pulse) begin
        errors++; $display("FAIL order%0d_commit: got %b/%h/%h/%h want 1/%h/%h/%h", k, bus.bvalid, bus.bresp,
                           reg_q, reg_wr, we.resp, we.img, we.pulse);
      end
      bus.bready = 1'b1;
      @(posedge aclk); #1;
      bus.bready = 1'b0;
      vectors++;
      if ({bus.bvalid, bus.awready, bus.wready} !== 3'b011) begin
        errors++; $display("FAIL order%0d_done: got %b want 011", k, {bus.bvalid, bus.awready, bus.wready});
      end
    end
  endtask

  task automatic test_backpressure_collision();
    wexp_t we; rexp_t re; resp_t r0; data_t d0;
    run_table("pre", '{BASE + 8}, '{32'h5}, '{4'hF}, '{});
    // Write held with bready low.
    push_wr(BASE + 24, 32'h7777_0006, 4'hF);
    bus.awaddr = BASE + 24; bus.wdata = 32'h7777_0006; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    @(posedge aclk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    r0 = bus.bresp;
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if ({bus.bvalid, bus.awready, bus.wready} !== 3'b100 || bus.bresp !== r0) begin
        errors++; $display("FAIL bp_write[%0d]: got %b resp %h want 100 resp %h", c,
                           {bus.bvalid, bus.awready, bus.wready}, bus.bresp, r0);
      end
      @(posedge aclk); #1;
    end
    we = bq.pop_front();
    vectors++;
    if (bus.bresp !== we.resp || reg_q !== we.img) begin
      errors++; $display("FAIL bp_write_result: got %h/%h want %h/%h", bus.bresp, reg_q, we.resp, we.img);
    end
    bus.bready = 1'b1; @(posedge aclk); #1; bus.bready = 1'b0;
    // Read held with rready low.
    push_rd(BASE + 24);
    bus.araddr = BASE + 24; bus.arvalid = 1'b1;
    @(posedge aclk); #1;
    bus.arvalid = 1'b0;
    re = rq.pop_front();
    d0 = bus.rdata;
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if ({bus.rvalid, bus.arready} !== 2'b10 || bus.rdata !== re.data || bus.rresp !== re.resp) begin
        errors++; $display("FAIL bp_read[%0d]: got %b %h/%h want 10 %h/%h", c, {bus.rvalid, bus.arready},
                           bus.rdata, bus.rresp, re.data, re.resp);
      end
      @(posedge aclk); #1;
    end
    vectors++;
    if (bus.rdata !== d0) begin
      errors++; $display("FAIL bp_read_stable: got %h want %h", bus.rdata, d0);
    end
    bus.rready = 1'b1; @(posedge aclk); #1; bus.rready = 1'b0;
    // Same-edge read and write of reg2: read sees the old value.
    push_rd(BASE + 8);
    push_wr(BASE + 8, 32'h9, 4'hF);
    bus.awaddr = BASE + 8; bus.wdata = 32'h9; bus.wstrb = 4'hF; bus.araddr = BASE + 8;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
    @(posedge aclk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    re = rq.pop_front(); we = bq.pop_front();
    vectors++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== re.data || re.data !== 32'h5) begin
      errors++; $display("FAIL collide_read: got %b/%h want 1/%h", bus.rvalid, bus.rdata, re.data);
    end
    vectors++;
    if (bus.bvalid !== 1'b1 || bus.bresp !== we.resp || reg_q !== we.img) begin
      errors++; $display("FAIL collide_write: got %b/%h/%h want 1/%h/%h", bus.bvalid, bus.bresp, reg_q, we.resp, we.img);
    end
    bus.bready = 1'b1; bus.rready = 1'b1;
    @(posedge aclk); #1;
    bus.bready = 1'b0; bus.rready = 1'b0;
    run_table("after_collide", '{}, '{}, '{}, '{BASE + 8});
  endtask

  task automatic test_async_reset();
    run_table("pre_rst", '{BASE + 20}, '{32'h0000_1234}, '{4'hF}, '{});
    bus.araddr = BASE + 20; bus.arvalid = 1'b1;
    @(posedge aclk); #1;
    bus.arvalid = 1'b0;
    vectors++;
    if (bus.rvalid !== 1'b1) begin
      errors++; $display("FAIL rst_pre_rvalid: got %b want 1", bus.rvalid);
    end
    #2 aresetn = 1'b0;
    #1;
    vectors++;
    if ({bus.rvalid, bus.arready, bus.awready, bus.wready} !== 4'b0 || reg_q !== '0 || bus.rdata !== '0) begin
      errors++; $display("FAIL rst_async: got %b regs %h rdata %h want 0000 regs 0 rdata 0",
                         {bus.rvalid, bus.arready, bus.awready, bus.wready}, reg_q, bus.rdata);
    end
    img = '0;
    bq.delete(); rq.delete();
    repeat (2) @(posedge aclk);
    @(negedge aclk); aresetn = 1'b1; bus.rready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge aclk); #1;
      vectors++;
      if (bus.rvalid !== 1'b0) begin
        errors++; $display("FAIL rst_stale_r[%0d]: got rvalid %b want 0", c, bus.rvalid);
      end
    end
    bus.rready = 1'b0;
    run_table("post_rst", '{BASE + 4}, '{32'h0F0F_0F0F}, '{4'b0011}, '{BASE + 20, BASE + 4});
  endtask

  initial begin
    test_reset();
    test_basic();
    test_strobe();
    test_ordering();
    test_oor();
    test_backpressure_collision();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/axi_lite_regs.md
# axi_lite_regs

AXI4-Lite slave register bank. It is the responder end of `axi_lite_if`: it connects through the `slave` modport and serves `N_REGS` 32-bit read/write registers to any `master` on the bus. Register contents and per-register write strobes are driven out to the surrounding logic. The block is used as the control/status endpoint behind an AXI-Lite interconnect or directly behind a master.

## Interface
Parameters:
- `N_REGS`, default 8: number of 32-bit registers, 1..256.
- `BASE_ADDR`, default 32'h0000_0000: byte address of register 0. Must be 4-byte aligned.

Ports:
- `aclk`  in  1: the single clock.
- `aresetn`  in  1: reset, asynchronous and active-low.
- `s_axi`  `axi_lite_if.slave`  n/a: AXI-Lite slave port. Widths come from `axi_lite_pkg`: `addr_t` 32 bits, `data_t` 32 bits, `strb_t` 4 bits, `resp_t` 2 bits.
- `reg_q`  out  N_REGS*32: current register contents. Register i occupies bits [32*i+31:32*i].
- `reg_wr`  out  N_REGS: one-cycle pulse on bit i when register i has been written.

## Operation
Address decode:
- idx = (addr − BASE_ADDR) >> 2.
- addr[1:0] is ignored.
- The address is in range when BASE_ADDR ≤ addr and idx < N_REGS.
- Out-of-range access gets resp = SLVERR (2'b10). An out-of-range write has no side effect; an out-of-range read returns rdata = 0.
- In-range access gets resp = OKAY (2'b00).

Write path, FSM {WR_IDLE, WR_RESP}:
- WR_IDLE: awready and wready are high while their respective address/data has not yet been captured.
  - AW and W are captured independently, in either order or in the same cycle.
  - A captured channel drops its ready until the response completes.
- The commit happens on the edge where the second of the two handshakes completes. On that edge:
  - For each byte b with wstrb[b] = 1, reg[idx][8b+7:8b] ← wdata[8b+7:8b].
  - bvalid ← 1 and bresp is set; the FSM moves to WR_RESP.
  - reg_wr[idx] ← 1 for exactly one cycle, only if the address is in range (wstrb = 0 still pulses).
- WR_RESP: bvalid holds and bresp stays stable until bready is high. On the bvalid&&bready edge the FSM returns to WR_IDLE and awready/wready rise again.

Read path, FSM {RD_IDLE, RD_RESP}, fully independent of the write path:
- RD_IDLE: arready is high. On the arvalid&&arready edge, rdata, rresp and rvalid ← 1 are registered, arready drops, and the FSM moves to RD_RESP.
- RD_RESP: rvalid, rdata and rresp hold stable until rready. On the rvalid&&rready edge the FSM returns to RD_IDLE.

Collision rule:
- If a read handshake and a write commit to the same register happen on the same edge, rdata carries the pre-write value.
- A read whose handshake edge is after the commit edge sees the new value.

Reset (aresetn low, asynchronous):
- All registers are 0; reg_wr = 0.
- arready, awready and wready are 0. bvalid and rvalid are 0. bresp, rresp and rdata are 0.
- Both FSMs go to IDLE and any partially captured AW/W is discarded.
- The ready signals rise on the first aclk edge after aresetn deasserts.
- Reset mid-transaction drops the transaction; no response is issued afterwards.

## Timing
- Write latency: bvalid is high in the cycle immediately after the completing handshake. The register value is visible on reg_q in that same cycle.
- Read latency: rvalid is high in the cycle immediately after the AR handshake.
- Throughput per path, with bready/rready held high: one transaction every 2 cycles.
- The read and write paths may complete in the same cycle.
- Valid signals never depend combinationally on ready. Outputs are registered, with no combinational path from inputs to outputs.
- Backpressure: while bvalid or rvalid is held, the next transaction on that path is not accepted.

## Test plan
- Reset release, then write 32'hDEAD_BEEF to BASE_ADDR+4 with wstrb = 4'hF -> bresp = 0, reg_q[63:32] = 32'hDEAD_BEEF, reg_wr = 8'h02 for one cycle. A read of BASE_ADDR+4 returns 32'hDEAD_BEEF with rresp = 0, rvalid one cycle after the AR handshake.
- Strobes: reg0 = 32'h1122_3344, then write 32'hAABB_CCDD with wstrb = 4'b0101 -> reg0 = 32'h11BB_33DD.
- Ordering: AW 3 cycles before W, then W 3 cycles before AW -> both commit on the later handshake, and awready/wready drop after their own capture.
- Out-of-range: write/read at BASE_ADDR + 4*N_REGS (0x20) -> SLVERR, rdata = 0, no register changes, reg_wr stays 0.
- Backpressure and collision: hold bready/rready low for 5 cycles -> bvalid/rvalid and data stay stable and arready/awready stay low. A same-edge read of and write to reg2 (old 5, new 9) -> rdata = 5; the next read returns 9.
- Async reset asserted while rvalid is held high -> rvalid, arready and all registers go to 0 immediately without waiting for a clock edge. Normal operation resumes after release.
